reg_native_arbiter: RTL and testbench

//  Shares one register native interface (req_vld/ack_vld handshake) among N_REQ native requesters,
//  e.g. several APB bridges driving one register block or CDC channel. Captures single-cycle

---
 rtl/reg_native_arbiter.sv | 175 +++++++++++++++++
 tb/tb_reg_native_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_native_arbiter.sv
// rtl/reg_native_arbiter.sv - round-robin arbiter sharing one register native interface among N_REQ ports
// Optional REG_ARB_TIMEOUT_EN: forced error completion after TIMEOUT_CYCLES in WAIT.
module reg_native_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ADDR_WIDTH     = 48,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [N_REQ-1:0]              m_req_vld,
  input  logic [N_REQ-1:0]              m_wr_en,
  input  logic [N_REQ-1:0]              m_rd_en,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   m_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   m_wr_data,
  input  logic [N_REQ-1:0]              m_non_sec,
  output logic [N_REQ-1:0]              m_ack_vld,
  output logic [DATA_WIDTH-1:0]         m_rd_data,
  output logic                          m_err,
  output logic [N_REQ-1:0]              req_overrun,
  output logic                          s_req_vld,
  output logic                          s_wr_en,
  output logic                          s_rd_en,
  output logic [ADDR_WIDTH-1:0]         s_addr,
  output logic [DATA_WIDTH-1:0]         s_wr_data,
  output logic                          s_non_sec,
  input  logic                          s_ack_vld,
  input  logic [DATA_WIDTH-1:0]         s_rd_data,
  input  logic                          s_err,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                r_state;
  logic [N_REQ-1:0]      r_pending;
  logic [N_REQ-1:0]      r_wr;
  logic [N_REQ-1:0]      r_rd;
  logic [N_REQ-1:0]      r_ns;
  logic [ADDR_WIDTH-1:0] r_addr  [N_REQ];
  logic [DATA_WIDTH-1:0] r_wdata [N_REQ];
  logic [IDW-1:0]        r_rr_ptr;

  logic [IDW-1:0]        w_winner;
  logic                  w_any;
  int                    w_idx;
  logic                  w_timeout;
  logic                  w_done;
  logic [N_REQ-1:0]      w_clr;
  logic [N_REQ-1:0]      w_accept;

`ifdef REG_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_tcnt;

  // Counter sits at zero outside WAIT, so it restarts on every WAIT entry
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)
      r_tcnt <= '0;
    else if (r_state != WAIT)
      r_tcnt <= '0;
    else
      r_tcnt <= r_tcnt + 1'b1;
  end

  assign w_timeout = (r_state == WAIT) && (r_tcnt == CW'(TIMEOUT_CYCLES - 1));
`else
  wire w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout = 1'b0;
`endif

  assign w_done   = ((r_state == ISSUE) || (r_state == WAIT)) && (s_ack_vld || w_timeout);
  assign w_clr    = w_done ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;
  // A port whose pending bit clears this edge may be re-armed on the same edge
  assign w_accept = m_req_vld & (~r_pending | w_clr);
  assign busy     = (r_state != IDLE);

  // Descending scan so the smallest offset from rr_ptr is the final winner
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= N_REQ)
        w_idx = w_idx - N_REQ;
      if (r_pending[w_idx]) begin
        w_any    = 1'b1;
        w_winner = IDW'(w_idx);
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_ns        <= '0;
      r_rr_ptr    <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
      end
      grant_id    <= '0;
      m_ack_vld   <= '0;
      m_rd_data   <= '0;
      m_err       <= 1'b0;
      req_overrun <= '0;
      s_req_vld   <= 1'b0;
      s_wr_en     <= 1'b0;
      s_rd_en     <= 1'b0;
      s_addr      <= '0;
      s_wr_data   <= '0;
      s_non_sec   <= 1'b0;
    end else begin
      req_overrun <= m_req_vld & r_pending & ~w_clr;
      r_pending   <= (r_pending & ~w_clr) | w_accept;
      for (int i = 0; i < N_REQ; i++) begin
        if (w_accept[i]) begin
          r_wr[i]    <= m_wr_en[i];
          r_rd[i]    <= m_rd_en[i];
          r_ns[i]    <= m_non_sec[i];
          r_addr[i]  <= m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          r_wdata[i] <= m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      m_ack_vld <= '0;
      m_rd_data <= '0;
      m_err     <= 1'b0;
      s_req_vld <= 1'b0;
      s_wr_en   <= 1'b0;
      s_rd_en   <= 1'b0;
      s_addr    <= '0;
      s_wr_data <= '0;
      s_non_sec <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_any) begin
            grant_id  <= w_winner;
            s_req_vld <= 1'b1;
            s_wr_en   <= r_wr[w_winner];
            s_rd_en   <= r_rd[w_winner];
            s_addr    <= r_addr[w_winner];
            s_wr_data <= r_wdata[w_winner];
            s_non_sec <= r_ns[w_winner];
            r_state   <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (w_done) begin
            m_ack_vld <= w_clr;
            // A real ack beats a coincident timeout
            if (s_ack_vld) begin
              m_rd_data <= s_rd_data;
              m_err     <= s_err;
            end else begin
              m_err     <= 1'b1;
            end
            r_rr_ptr <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            r_state  <= IDLE;
          end else begin
            r_state  <= WAIT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_native_arbiter.sv
// tb/tb_reg_native_arbiter.sv - directed self-checking bench for reg_native_arbiter
// Timeout scenario runs only when REG_ARB_TIMEOUT_EN is defined.
module tb_reg_native_arbiter;
  localparam int N  = 4;
  localparam int AW = 48;
  localparam int DW = 32;

  logic            pclk = 1'b0;
  logic            presetn;
  logic [N-1:0]    m_req_vld, m_wr_en, m_rd_en, m_non_sec;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wr_data;
  logic [N-1:0]    m_ack_vld, req_overrun;
  logic [DW-1:0]   m_rd_data;
  logic            m_err;
  logic            s_req_vld, s_wr_en, s_rd_en, s_non_sec;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wr_data;
  logic            s_ack_vld;
  logic [DW-1:0]   s_rd_data;
  logic            s_err;
  logic [1:0]      grant_id;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  reg_native_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .pclk(pclk), .presetn(presetn),
    .m_req_vld(m_req_vld), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en),
    .m_addr(m_addr), .m_wr_data(m_wr_data), .m_non_sec(m_non_sec),
    .m_ack_vld(m_ack_vld), .m_rd_data(m_rd_data), .m_err(m_err),
    .req_overrun(req_overrun),
    .s_req_vld(s_req_vld), .s_wr_en(s_wr_en), .s_rd_en(s_rd_en),
    .s_addr(s_addr), .s_wr_data(s_wr_data), .s_non_sec(s_non_sec),
    .s_ack_vld(s_ack_vld), .s_rd_data(s_rd_data), .s_err(s_err),
    .grant_id(grant_id), .busy(busy)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic req(input int p, input logic wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] data, input logic ns);
    m_req_vld[p]         = 1'b1;
    m_wr_en[p]           = wr;
    m_rd_en[p]           = !wr;
    m_non_sec[p]         = ns;
    m_addr[p*AW +: AW]   = addr;
    m_wr_data[p*DW +: DW] = data;
  endtask

  // Wait (bounded) for the downstream request, check it, ack after 'delay' cycles
  task automatic serve(input string tag, input int gid, input logic exp_wr,
                       input logic [AW-1:0] exp_addr, input logic [DW-1:0] rdata,
                       input logic err, input int delay);
    int n = 0;
    while (s_req_vld !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_sreq"}, s_req_vld, 1);
    chk({tag, "_gid"}, grant_id, gid);
    chk({tag, "_addr"}, s_addr, exp_addr);
    chk({tag, "_wr"}, {s_wr_en, s_rd_en}, {exp_wr, !exp_wr});
    for (int d = 0; d < delay; d++) tick();
    s_ack_vld = 1'b1; s_rd_data = rdata; s_err = err;
    tick();
    s_ack_vld = 1'b0; s_rd_data = '0; s_err = 1'b0;
    chk({tag, "_ack"}, m_ack_vld, 4'b0001 << gid);
    chk({tag, "_rdata"}, m_rd_data, rdata);
    chk({tag, "_err"}, m_err, err);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    presetn = 1'b0;
    m_req_vld = '0; m_wr_en = '0; m_rd_en = '0; m_non_sec = '0;
    m_addr = '0; m_wr_data = '0;
    s_ack_vld = 1'b0; s_rd_data = '0; s_err = 1'b0;
    tick(); tick(); tick();
    chk("rst_ack", m_ack_vld, 0);
    chk("rst_rdata", m_rd_data, 0);
    chk("rst_err", m_err, 0);
    chk("rst_ovr", req_overrun, 0);
    chk("rst_sreq", s_req_vld, 0);
    chk("rst_saddr", s_addr, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 0);
    presetn = 1'b1;
    tick();

    // 1: port 0 write, ack two cycles after s_req_vld
    req(0, 1'b1, 48'h10, 32'hA5A5_0000, 1'b1);
    tick();
    m_req_vld = '0;
    chk("t1_lat", s_req_vld, 0);
    tick();
    chk("t1_sreq", s_req_vld, 1);
    chk("t1_swr", {s_wr_en, s_rd_en}, 2'b10);
    chk("t1_saddr", s_addr, 48'h10);
    chk("t1_sdata", s_wr_data, 32'hA5A5_0000);
    chk("t1_sns", s_non_sec, 1);
    chk("t1_gid", grant_id, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_sreq_once", s_req_vld, 0);
    chk("t1_saddr0", s_addr, 0);
    tick();
    s_ack_vld = 1'b1;
    tick();
    s_ack_vld = 1'b0;
    chk("t1_ack", m_ack_vld, 4'b0001);
    chk("t1_err", m_err, 0);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_ack_pulse", m_ack_vld, 0);

    // 2: ports 0,1,3 together from a fresh pointer, immediate ack
    presetn = 1'b0;
    tick();
    presetn = 1'b1;
    req(0, 1'b1, 48'h100, 32'h1, 1'b0);
    req(1, 1'b1, 48'h110, 32'h2, 1'b0);
    req(3, 1'b0, 48'h130, 32'h3, 1'b0);
    tick();
    m_req_vld = '0;
    serve("t2a", 0, 1'b1, 48'h100, 32'h0, 1'b0, 0);
    serve("t2b", 1, 1'b1, 48'h110, 32'h0, 1'b0, 0);
    serve("t2c", 3, 1'b0, 48'h130, 32'h1111, 1'b0, 0);
    req(2, 1'b0, 48'h120, 32'h0, 1'b0);
    req(0, 1'b1, 48'h140, 32'h4, 1'b0);
    tick();
    m_req_vld = '0;
    serve("t2d", 0, 1'b1, 48'h140, 32'h0, 1'b0, 0);
    serve("t2e", 2, 1'b0, 48'h120, 32'h2222, 1'b0, 1);

    // 3: port 2 read, error ack in the ISSUE cycle
    req(2, 1'b0, 48'h200, 32'h0, 1'b0);
    tick();
    m_req_vld = '0;
    serve("t3", 2, 1'b0, 48'h200, 32'hDEAD_BEEF, 1'b1, 0);
    tick();
    chk("t3_ack_clr", m_ack_vld, 0);
    chk("t3_rdata_clr", m_rd_data, 0);
    chk("t3_err_clr", m_err, 0);

    // 4: port 1 pulses again while pending
    req(1, 1'b1, 48'h300, 32'h5, 1'b0);
    tick();
    tick();
    m_req_vld = '0;
    chk("t4_ovr", req_overrun, 4'b0010);
    chk("t4_sreq", s_req_vld, 1);
    tick();
    chk("t4_ovr_pulse", req_overrun, 0);
    chk("t4_wait", {s_req_vld, busy}, 2'b01);
    s_ack_vld = 1'b1;
    tick();
    s_ack_vld = 1'b0;
    chk("t4_ack", m_ack_vld, 4'b0010);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_req_vld === 1'b1) cnt++;
    end
    chk("t4_single_issue", cnt, 0);

    // 4b: re-request on the completing cycle is accepted without overrun
    req(1, 1'b1, 48'h310, 32'h6, 1'b0);
    tick();
    m_req_vld = '0;
    tick();
    chk("t4b_sreq", s_req_vld, 1);
    s_ack_vld = 1'b1;
    req(1, 1'b1, 48'h320, 32'h7, 1'b0);
    tick();
    s_ack_vld = 1'b0;
    m_req_vld = '0;
    chk("t4b_ack", m_ack_vld, 4'b0010);
    chk("t4b_no_ovr", req_overrun, 0);
    serve("t4b_again", 1, 1'b1, 48'h320, 32'h0, 1'b0, 0);

    // 5: reset during WAIT, stray ack afterwards
    req(3, 1'b1, 48'h400, 32'h8, 1'b0);
    tick();
    m_req_vld = '0;
    tick();
    tick();
    chk("t5_in_wait", {s_req_vld, busy}, 2'b01);
    presetn = 1'b0;
    #2;
    chk("t5_busy_async", busy, 0);
    chk("t5_gid", grant_id, 0);
    tick();
    presetn = 1'b1;
    s_ack_vld = 1'b1;
    s_rd_data = 32'h55;
    tick();
    s_ack_vld = 1'b0;
    s_rd_data = '0;
    chk("t5_no_ack", m_ack_vld, 0);
    chk("t5_rdata", m_rd_data, 0);
    chk("t5_err", m_err, 0);
    tick();
    chk("t5_no_reissue", {s_req_vld, busy}, 2'b00);

`ifdef REG_ARB_TIMEOUT_EN
    // 6: no ack, forced error completion eight cycles into WAIT
    req(0, 1'b0, 48'h500, 32'h0, 1'b0);
    tick();
    m_req_vld = '0;
    tick();
    chk("t6_sreq", s_req_vld, 1);
    s_rd_data = 32'hFFFF_FFFF;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m_ack_vld !== 4'b0000) cnt++;
    end
    chk("t6_early_ack", cnt, 0);
    tick();
    chk("t6_ack", m_ack_vld, 4'b0001);
    chk("t6_err", m_err, 1);
    chk("t6_rdata", m_rd_data, 0);
    chk("t6_idle", busy, 0);
    s_rd_data = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
